// File: rtl/cc_regport_arbiter_if.sv
// Request/grant bundle between the MIR and scratchpad requesters and the
// register-file address port arbiter.
interface cc_regport_arbiter_if #(
  parameter int unsigned DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int unsigned DATAWIDTH_MIR_DIRECTION        = 6
);
  logic                                      CC_REGPORT_ARBITER_MIRReq_In;
  logic [DATAWIDTH_MIR_DIRECTION-1:0]        CC_REGPORT_ARBITER_MIRAddress_InBus;
  logic                                      CC_REGPORT_ARBITER_MIRWrite_In;
  logic                                      CC_REGPORT_ARBITER_SPReq_In;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] CC_REGPORT_ARBITER_SPAddress_InBus;
  logic                                      CC_REGPORT_ARBITER_SPWrite_In;
  logic                                      CC_REGPORT_ARBITER_MIRGrant_Out;
  logic                                      CC_REGPORT_ARBITER_SPGrant_Out;
  logic                                      CC_REGPORT_ARBITER_Select_Out;
  logic [DATAWIDTH_MIR_DIRECTION-1:0]        CC_REGPORT_ARBITER_Address_OutBus;
  logic                                      CC_REGPORT_ARBITER_Write_Out;
  logic                                      CC_REGPORT_ARBITER_Clear_Out;
  logic                                      CC_REGPORT_ARBITER_Busy_Out;

  modport master (
    output CC_REGPORT_ARBITER_MIRReq_In, CC_REGPORT_ARBITER_MIRAddress_InBus,
           CC_REGPORT_ARBITER_MIRWrite_In, CC_REGPORT_ARBITER_SPReq_In,
           CC_REGPORT_ARBITER_SPAddress_InBus, CC_REGPORT_ARBITER_SPWrite_In,
    input  CC_REGPORT_ARBITER_MIRGrant_Out, CC_REGPORT_ARBITER_SPGrant_Out,
           CC_REGPORT_ARBITER_Select_Out, CC_REGPORT_ARBITER_Address_OutBus,
           CC_REGPORT_ARBITER_Write_Out, CC_REGPORT_ARBITER_Clear_Out,
           CC_REGPORT_ARBITER_Busy_Out
  );

  modport slave (
    input  CC_REGPORT_ARBITER_MIRReq_In, CC_REGPORT_ARBITER_MIRAddress_InBus,
           CC_REGPORT_ARBITER_MIRWrite_In, CC_REGPORT_ARBITER_SPReq_In,
           CC_REGPORT_ARBITER_SPAddress_InBus, CC_REGPORT_ARBITER_SPWrite_In,
    output CC_REGPORT_ARBITER_MIRGrant_Out, CC_REGPORT_ARBITER_SPGrant_Out,
           CC_REGPORT_ARBITER_Select_Out, CC_REGPORT_ARBITER_Address_OutBus,
           CC_REGPORT_ARBITER_Write_Out, CC_REGPORT_ARBITER_Clear_Out,
           CC_REGPORT_ARBITER_Busy_Out
  );
endinterface

// File: rtl/cc_regport_arbiter.sv
// Round-robin arbiter for the shared register-file address port, with a
// post-reset sweep that writes every register address once to clear the file.
module cc_regport_arbiter #(
  parameter int unsigned DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int unsigned DATAWIDTH_MIR_DIRECTION        = 6,
  parameter int unsigned MAX_BURST                      = 4,
  parameter bit          CLEAR_ON_RESET                 = 1'b1
) (
  input logic               CC_REGPORT_ARBITER_CLOCK_50,
  input logic               CC_REGPORT_ARBITER_RESET_InLow,
  cc_regport_arbiter_if.slave port
);
  localparam int unsigned addrWidth  = DATAWIDTH_MIR_DIRECTION;
  localparam int unsigned sweepWidth = DATAWIDTH_MIR_DIRECTION + 1;
  localparam int unsigned burstWidth = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {CLEAR, IDLE, GNT_MIR, GNT_SP} arbState_t;

  arbState_t state, stateNext;
  logic [sweepWidth-1:0] sweepCount, sweepNext;
  logic [burstWidth-1:0] burstCount, burstNext;
  logic lastMir, lastMirNext;
  logic mirGrantQ, mirGrantNext, spGrantQ, spGrantNext;
  logic selectQ, selectNext, writeQ, writeNext, clearQ, clearNext, busyQ, busyNext;
  logic [addrWidth-1:0] addressQ, addressNext;
  logic takeMir, takeSp, keepMir, keepSp, burstFull;

  logic                                      mirReq, spReq;
  logic [addrWidth-1:0]                      mirAddress;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] spAddress;

  assign mirReq     = port.CC_REGPORT_ARBITER_MIRReq_In;
  assign spReq      = port.CC_REGPORT_ARBITER_SPReq_In;
  assign mirAddress = port.CC_REGPORT_ARBITER_MIRAddress_InBus;
  assign spAddress  = port.CC_REGPORT_ARBITER_SPAddress_InBus;
  assign burstFull  = (burstCount == burstWidth'(MAX_BURST));

  // Next-state and next-output decode; the sweep is done once its counter's MSB sets.
  always_comb begin
    stateNext    = state;
    sweepNext    = sweepCount;
    burstNext    = burstCount;
    lastMirNext  = lastMir;
    mirGrantNext = 1'b0;
    spGrantNext  = 1'b0;
    selectNext   = selectQ;
    addressNext  = addressQ;
    writeNext    = 1'b0;
    clearNext    = 1'b0;
    takeMir      = 1'b0;
    takeSp       = 1'b0;
    keepMir      = 1'b0;
    keepSp       = 1'b0;

    unique case (state)
      CLEAR: begin
        if (sweepCount[sweepWidth-1]) begin
          stateNext = IDLE;
        end else begin
          addressNext = sweepCount[addrWidth-1:0];
          writeNext   = 1'b1;
          clearNext   = 1'b1;
          selectNext  = 1'b1;
          sweepNext   = sweepCount + sweepWidth'(1);
        end
      end
      IDLE: begin
        if (mirReq && (!spReq || !lastMir)) takeMir = 1'b1;
        else if (spReq)                     takeSp  = 1'b1;
      end
      GNT_MIR: begin
        if (!mirReq) begin
          if (spReq) takeSp = 1'b1;
          else       stateNext = IDLE;
        end else if (burstFull && spReq) begin
          takeSp = 1'b1;
        end else begin
          keepMir = 1'b1;
        end
      end
      GNT_SP: begin
        if (!spReq) begin
          if (mirReq) takeMir = 1'b1;
          else        stateNext = IDLE;
        end else if (burstFull && mirReq) begin
          takeMir = 1'b1;
        end else begin
          keepSp = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // New owner: burst restarts at one and round-robin pointer moves.
    if (takeMir || takeSp) begin
      stateNext   = takeMir ? GNT_MIR : GNT_SP;
      burstNext   = burstWidth'(1);
      lastMirNext = takeMir;
    end else if ((keepMir || keepSp) && !burstFull) begin
      burstNext = burstCount + burstWidth'(1);
    end

    if (takeMir || keepMir) begin
      mirGrantNext = 1'b1;
      selectNext   = 1'b1;
      addressNext  = mirAddress;
      writeNext    = port.CC_REGPORT_ARBITER_MIRWrite_In;
    end else if (takeSp || keepSp) begin
      spGrantNext = 1'b1;
      selectNext  = 1'b0;
      addressNext = addrWidth'(spAddress);
      writeNext   = port.CC_REGPORT_ARBITER_SPWrite_In;
    end

    busyNext = (stateNext != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CC_REGPORT_ARBITER_CLOCK_50 or negedge CC_REGPORT_ARBITER_RESET_InLow) begin
    if (!CC_REGPORT_ARBITER_RESET_InLow) begin
      state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      sweepCount <= '0;
      burstCount <= '0;
      lastMir    <= 1'b0;
      mirGrantQ  <= 1'b0;
      spGrantQ   <= 1'b0;
      selectQ    <= 1'b0;
      addressQ   <= '0;
      writeQ     <= 1'b0;
      clearQ     <= 1'b0;
      busyQ      <= CLEAR_ON_RESET;
    end else begin
      state      <= stateNext;
      sweepCount <= sweepNext;
      burstCount <= burstNext;
      lastMir    <= lastMirNext;
      mirGrantQ  <= mirGrantNext;
      spGrantQ   <= spGrantNext;
      selectQ    <= selectNext;
      addressQ   <= addressNext;
      writeQ     <= writeNext;
      clearQ     <= clearNext;
      busyQ      <= busyNext;
    end
  end

  assign port.CC_REGPORT_ARBITER_MIRGrant_Out   = mirGrantQ;
  assign port.CC_REGPORT_ARBITER_SPGrant_Out    = spGrantQ;
  assign port.CC_REGPORT_ARBITER_Select_Out     = selectQ;
  assign port.CC_REGPORT_ARBITER_Address_OutBus = addressQ;
  assign port.CC_REGPORT_ARBITER_Write_Out      = writeQ;
  assign port.CC_REGPORT_ARBITER_Clear_Out      = clearQ;
  assign port.CC_REGPORT_ARBITER_Busy_Out       = busyQ;
endmodule

// File: tb/tb_cc_regport_arbiter.sv
// Bench for cc_regport_arbiter: fixed vector table, hand-built reset/sweep
// sequences and random traffic compared against a behavioural model.
module tb_cc_regport_arbiter;
  localparam int NREG = 64;
  localparam int MAXB = 4;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cc_regport_arbiter_if #(.DATAWIDTH_SCRATCHPAD_DIRECTION(5), .DATAWIDTH_MIR_DIRECTION(6)) bus ();

  cc_regport_arbiter #(
    .DATAWIDTH_SCRATCHPAD_DIRECTION(5),
    .DATAWIDTH_MIR_DIRECTION(6),
    .MAX_BURST(MAXB),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .CC_REGPORT_ARBITER_CLOCK_50(clk),
    .CC_REGPORT_ARBITER_RESET_InLow(rstN),
    .port(bus)
  );

  typedef struct {
    logic       mReq;
    logic [5:0] mAddr;
    logic       mWr;
    logic       sReq;
    logic [4:0] sAddr;
    logic       sWr;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model: owner index 0 = MIR, 1 = SP, -1 = nobody; mClr >= 0 while sweeping.
  int mClr, mOwner, mRun, mLast;
  bit eGm, eGs, eSel, eW, eC, eB;
  logic [5:0] eA;

  function automatic logic [11:0] pack(bit gm, bit gs, bit sel, logic [5:0] a, bit w, bit c, bit b);
    return {gm, gs, sel, a, w, c, b};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.CC_REGPORT_ARBITER_MIRGrant_Out, bus.CC_REGPORT_ARBITER_SPGrant_Out,
            bus.CC_REGPORT_ARBITER_Select_Out, bus.CC_REGPORT_ARBITER_Address_OutBus,
            bus.CC_REGPORT_ARBITER_Write_Out, bus.CC_REGPORT_ARBITER_Clear_Out,
            bus.CC_REGPORT_ARBITER_Busy_Out};
  endfunction

  task automatic modelReset();
    mClr = 0; mOwner = -1; mRun = 0; mLast = 1;
    eGm = 0; eGs = 0; eSel = 0; eA = '0; eW = 0; eC = 0; eB = 1;
  endtask

  task automatic modelEdge();
    bit req[2];
    logic [5:0] ad[2];
    bit wr[2];
    int nxt, oth;
    req[0] = bus.CC_REGPORT_ARBITER_MIRReq_In;
    req[1] = bus.CC_REGPORT_ARBITER_SPReq_In;
    ad[0]  = bus.CC_REGPORT_ARBITER_MIRAddress_InBus;
    ad[1]  = {1'b0, bus.CC_REGPORT_ARBITER_SPAddress_InBus};
    wr[0]  = bus.CC_REGPORT_ARBITER_MIRWrite_In;
    wr[1]  = bus.CC_REGPORT_ARBITER_SPWrite_In;
    if (mClr >= 0) begin
      eGm = 0; eGs = 0;
      if (mClr == NREG) begin
        mClr = -1; eW = 0; eC = 0; eB = 0;
      end else begin
        eA = 6'(mClr); eW = 1; eC = 1; eSel = 1; eB = 1; mClr++;
      end
      return;
    end
    nxt = mOwner;
    if (mOwner < 0) begin
      if (req[0] && req[1]) nxt = 1 - mLast;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else begin
      oth = 1 - mOwner;
      if (!req[mOwner])                   nxt = req[oth] ? oth : -1;
      else if (mRun == MAXB && req[oth])  nxt = oth;
    end
    if (nxt < 0) begin
      eGm = 0; eGs = 0; eW = 0; eB = 0;
    end else begin
      mRun  = (nxt == mOwner) ? ((mRun < MAXB) ? mRun + 1 : MAXB) : 1;
      mLast = nxt;
      eGm = (nxt == 0); eGs = (nxt == 1); eSel = (nxt == 0);
      eA = ad[nxt]; eW = wr[nxt]; eB = 1;
    end
    mOwner = nxt;
  endtask

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%03h exp=%03h (gm gs sel addr[6] wr clr busy)", name, got, exp);
    end
  endtask

  task automatic setIn(bit mReq, logic [5:0] mAddr, bit mWr, bit sReq, logic [4:0] sAddr, bit sWr);
    bus.CC_REGPORT_ARBITER_MIRReq_In        = mReq;
    bus.CC_REGPORT_ARBITER_MIRAddress_InBus = mAddr;
    bus.CC_REGPORT_ARBITER_MIRWrite_In      = mWr;
    bus.CC_REGPORT_ARBITER_SPReq_In         = sReq;
    bus.CC_REGPORT_ARBITER_SPAddress_InBus  = sAddr;
    bus.CC_REGPORT_ARBITER_SPWrite_In       = sWr;
  endtask

  // One clock: step the model on the edge, then compare 1 time unit later.
  task automatic tick(string name, bit useConst, logic [11:0] constExp);
    @(posedge clk);
    modelEdge();
    #1;
    if (useConst) check(name, observed(), constExp);
    else          check(name, observed(), pack(eGm, eGs, eSel, eA, eW, eC, eB));
  endtask

  task automatic asyncReset(string name);
    #3 rstN = 1'b0;
    modelReset();
    #1 check(name, observed(), 12'h001);
    #1 rstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int grantCount;
    vecs[0]  = '{0, 6'h00, 0, 1, 5'h1F, 1, pack(0, 1, 0, 6'h1F, 1, 0, 1)};
    vecs[1]  = '{0, 6'h00, 0, 0, 5'h1F, 1, pack(0, 0, 0, 6'h1F, 0, 0, 0)};
    vecs[2]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[3]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[4]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[5]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[6]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(0, 1, 0, 6'h03, 0, 0, 1)};
    vecs[7]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(0, 1, 0, 6'h03, 0, 0, 1)};
    vecs[8]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(0, 1, 0, 6'h03, 0, 0, 1)};
    vecs[9]  = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(0, 1, 0, 6'h03, 0, 0, 1)};
    vecs[10] = '{1, 6'h2A, 1, 1, 5'h03, 0, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[11] = '{0, 6'h2A, 1, 1, 5'h03, 1, pack(0, 1, 0, 6'h03, 1, 0, 1)};
    vecs[12] = '{1, 6'h2A, 1, 0, 5'h03, 1, pack(1, 0, 1, 6'h2A, 1, 0, 1)};
    vecs[13] = '{0, 6'h2A, 1, 0, 5'h03, 1, pack(0, 0, 1, 6'h2A, 0, 0, 0)};

    setIn(1, 6'h11, 1, 1, 5'h07, 1);
    modelReset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", observed(), 12'h001);
    #5 rstN = 1'b1;

    // Sweep with both requests held: no grant, addresses 0..63, then idle.
    for (int i = 0; i < NREG - 1; i++) tick($sformatf("sweep_%0d", i), 0, '0);
    tick("sweep_last", 1, pack(0, 0, 1, 6'h3F, 1, 1, 1));
    tick("sweep_done_idle", 1, pack(0, 0, 1, 6'h3F, 0, 0, 0));

    for (int i = 0; i < 14; i++) begin
      setIn(vecs[i].mReq, vecs[i].mAddr, vecs[i].mWr, vecs[i].sReq, vecs[i].sAddr, vecs[i].sWr);
      tick($sformatf("vec_%0d", i), 1, vecs[i].exp);
    end

    // Uncontended MIR keeps the port for 20 edges.
    grantCount = 0;
    for (int i = 0; i < 20; i++) begin
      setIn(1, 6'($urandom), 1'($urandom), 0, 5'($urandom), 1'($urandom));
      tick($sformatf("mir_hold_%0d", i), 0, '0);
      if (bus.CC_REGPORT_ARBITER_MIRGrant_Out) grantCount++;
    end
    checks++;
    if (grantCount != 20) begin
      errors++;
      $display("FAIL mir_hold_count got=%0d exp=20", grantCount);
    end

    asyncReset("reset_mid_grant");
    for (int i = 0; i <= 30; i++) tick($sformatf("sweep2_%0d", i), 0, '0);
    asyncReset("reset_mid_sweep");
    tick("sweep_restart", 1, pack(0, 0, 1, 6'h00, 1, 1, 1));
    for (int i = 1; i <= NREG; i++) tick($sformatf("sweep3_%0d", i), 0, '0);

    for (int i = 0; i < 400; i++) begin
      setIn($urandom_range(0, 99) < 60, 6'($urandom), 1'($urandom),
            $urandom_range(0, 99) < 60, 5'($urandom), 1'($urandom));
      tick($sformatf("rand_%0d", i), 0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
